// File: rtl/pfm_pred_arb.sv
`default_nettype none
// ============================================================================
// Module      : pfm_pred_arb
// Description : Prefetch prediction arbiter. Collects predictions from NREQ
//               independent prediction engines and schedules them onto the
//               single prefetch-monitor-to-core prediction channel.
//               Round-robin selection over the enabled, valid sources, a
//               programmable minimum gap between grants, and a 2-entry output
//               buffer that isolates the downstream retry from the upstream
//               retries.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1            rising-edge clock for all state
//   reset        in   1            asynchronous, active-low reset
//   req_data     in   NREQ*DATA_W  source i payload at [i*DATA_W +: DATA_W]
//   req_valid    in   NREQ         per-source valid
//   req_retry    out  NREQ         per-source retry (1 = not accepted)
//   cfg_enable   in   NREQ         per-source enable mask
//   cfg_min_gap  in   GAP_W        idle cycles forced between grants
//   pred_data    out  DATA_W       payload of the buffer head
//   pred_src     out  clog2(NREQ)  source index of the buffer head
//   pred_valid   out  1            buffer non-empty
//   pred_retry   in   1            downstream retry
// ============================================================================
module pfm_pred_arb #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 64,
    parameter int GAP_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_retry,
    input  logic [NREQ-1:0]           cfg_enable,
    input  logic [GAP_W-1:0]          cfg_min_gap,
    output logic [DATA_W-1:0]         pred_data,
    output logic [$clog2(NREQ)-1:0]   pred_src,
    output logic                      pred_valid,
    input  logic                      pred_retry
);

    localparam int                   C_SRC_W   = $clog2(NREQ);
    localparam logic [C_SRC_W:0]     C_NREQ    = (C_SRC_W + 1)'(NREQ);
    localparam logic [C_SRC_W-1:0]   C_LAST    = C_SRC_W'(NREQ - 1);
    localparam logic [C_SRC_W-1:0]   C_SRC_ONE = C_SRC_W'(1);
    localparam logic [GAP_W-1:0]     C_GAP_ONE = GAP_W'(1);
    localparam logic [1:0]           C_FULL    = 2'd2;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [C_SRC_W-1:0]  r_rr_ptr;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [1:0]          r_count;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [DATA_W-1:0]   r_mem_data [2];
    logic [C_SRC_W-1:0]  r_mem_src  [2];

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]   w_req_arr [NREQ];
    logic [NREQ-1:0]     w_cand;
    logic [C_SRC_W:0]    w_scan;
    logic                w_found;
    logic [C_SRC_W-1:0]  w_gnt_idx;
    logic                w_can_arb;
    logic                w_grant;
    logic [NREQ-1:0]     w_gnt_oh;
    logic                w_push;
    logic                w_pop;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_req_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Disabling a source removes it from the candidate set in the same cycle.
    assign w_cand = req_valid & cfg_enable;

    // Arbitration only looks at registered state (count, gap counter), so the
    // downstream retry never reaches the upstream retries combinationally.
    // A full buffer blocks the grant even if the head pops this cycle.
    assign w_can_arb = (r_count != C_FULL) && (r_gap_cnt == '0);

    // Round-robin scan starting at r_rr_ptr, wrapping modulo NREQ. The scan
    // index is one bit wider so the sum of pointer and offset cannot overflow
    // before the wrap correction.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (C_SRC_W + 1)'(k);
            if (w_scan >= C_NREQ) begin
                w_scan = w_scan - C_NREQ;
            end
            if (!w_found && w_cand[w_scan[C_SRC_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[C_SRC_W-1:0];
            end
        end
    end

    assign w_grant = w_can_arb && w_found;

    always_comb begin
        w_gnt_oh = '0;
        if (w_grant) begin
            w_gnt_oh[w_gnt_idx] = 1'b1;
        end
    end

    // While reset is held every source is refused, regardless of what the
    // (reset-valued) arbitration state would otherwise select.
    assign req_retry = reset ? ~w_gnt_oh : '1;

    assign w_push = w_grant;
    assign w_pop  = (r_count != 2'd0) && !pred_retry;

    // ------------------------------------------------------------------------
    // Arbitration state: round-robin pointer and minimum-gap counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr  <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_grant) begin
                r_rr_ptr  <= (w_gnt_idx == C_LAST) ? '0 : (w_gnt_idx + C_SRC_ONE);
                r_gap_cnt <= cfg_min_gap;
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - C_GAP_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // 2-entry output FIFO. Separate read/write pointers let a push and a pop
    // in the same cycle touch different slots, which preserves ordering.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_mem_data[i] <= '0;
                r_mem_src[i]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_req_arr[w_gnt_idx];
                r_mem_src[r_wr_ptr]  <= w_gnt_idx;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pred_valid = (r_count != 2'd0);
    assign pred_data  = r_mem_data[r_rd_ptr];
    assign pred_src   = r_mem_src[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_pfm_pred_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_pfm_pred_arb
// Description : Self-checking bench for pfm_pred_arb. Directed scenarios with
//               hand-derived expectations plus a randomized run checked
//               against an in-order scoreboard and a fairness bound.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pfm_pred_arb;

    localparam int NREQ   = 4;
    localparam int DATA_W = 64;
    localparam int GAP_W  = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ*DATA_W-1:0]  req_data;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_retry;
    logic [NREQ-1:0]         cfg_enable;
    logic [GAP_W-1:0]        cfg_min_gap;
    logic [DATA_W-1:0]       pred_data;
    logic [1:0]              pred_src;
    logic                    pred_valid;
    logic                    pred_retry;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] dat [NREQ];

    always #5 clk = ~clk;

    pfm_pred_arb #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .GAP_W  (GAP_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_retry   (req_retry),
        .cfg_enable  (cfg_enable),
        .cfg_min_gap (cfg_min_gap),
        .pred_data   (pred_data),
        .pred_src    (pred_src),
        .pred_valid  (pred_valid),
        .pred_retry  (pred_retry)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = dat[i];
        end
    endtask

    function automatic logic [3:0] gnt_retry(input int g);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << g);
    endfunction

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset       = 1'b0;
        req_valid   = '1;
        cfg_enable  = '1;
        cfg_min_gap = '0;
        pred_retry  = 1'b0;
        load_data();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (pred_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_pred_valid got=%b exp=0", pred_valid);
        end
        n_vec++;
        if (pred_data !== 64'd0) begin
            n_err++; $display("FAIL reset_pred_data got=%h exp=0", pred_data);
        end
        n_vec++;
        if (pred_src !== 2'd0) begin
            n_err++; $display("FAIL reset_pred_src got=%0d exp=0", pred_src);
        end
        n_vec++;
        if (req_retry !== 4'b1111) begin
            n_err++; $display("FAIL reset_req_retry got=%b exp=1111", req_retry);
        end
        req_valid = '0;
        step();
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_round_robin();
        logic [3:0] er;
        logic [1:0] es;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            er = gnt_retry(k % 4);
            n_vec++;
            if (req_retry !== er) begin
                n_err++; $display("FAIL rr_retry k=%0d got=%b exp=%b", k, req_retry, er);
            end
            if (k >= 1) begin
                es = 2'((k - 1) % 4);
                n_vec++;
                if (pred_valid !== 1'b1 || pred_src !== es || pred_data !== dat[es]) begin
                    n_err++;
                    $display("FAIL rr_out k=%0d got v=%b src=%0d data=%h exp v=1 src=%0d data=%h",
                             k, pred_valid, pred_src, pred_data, es, dat[es]);
                end
            end
            step();
        end
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_src !== 2'd3 || req_retry !== 4'b1111) begin
            n_err++;
            $display("FAIL rr_tail got v=%b src=%0d retry=%b exp v=1 src=3 retry=1111",
                     pred_valid, pred_src, req_retry);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (pred_valid !== 1'b0) begin
            n_err++; $display("FAIL rr_drain got v=%b exp v=0", pred_valid);
        end
        step();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_min_gap();
        logic [3:0] er;
        logic       ev;
        cfg_min_gap = 4'd3;
        req_valid   = 4'b0100;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            er = ((k % 4) == 0) ? 4'b1011 : 4'b1111;
            ev = ((k % 4) == 1);
            n_vec++;
            if (req_retry !== er) begin
                n_err++; $display("FAIL gap_retry k=%0d got=%b exp=%b", k, req_retry, er);
            end
            n_vec++;
            if (pred_valid !== ev || (ev && (pred_src !== 2'd2 || pred_data !== dat[2]))) begin
                n_err++;
                $display("FAIL gap_out k=%0d got v=%b src=%0d exp v=%b src=2",
                         k, pred_valid, pred_src, ev);
            end
            step();
        end
        req_valid   = '0;
        cfg_min_gap = '0;
        repeat (4) step();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        logic [3:0] er [7];
        logic       ev [7];
        logic [1:0] es [7];
        er = '{4'b1110, 4'b1101, 4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1101};
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        es = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        pred_retry = 1'b1;
        req_valid  = 4'b0011;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) pred_retry = 1'b0;
            @(negedge clk);
            n_vec++;
            if (req_retry !== er[k]) begin
                n_err++; $display("FAIL bp_retry k=%0d got=%b exp=%b", k, req_retry, er[k]);
            end
            n_vec++;
            if (pred_valid !== ev[k] ||
                (ev[k] && (pred_src !== es[k] || pred_data !== dat[es[k]]))) begin
                n_err++;
                $display("FAIL bp_out k=%0d got v=%b src=%0d exp v=%b src=%0d",
                         k, pred_valid, pred_src, ev[k], es[k]);
            end
            step();
        end
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_src !== 2'd1) begin
            n_err++; $display("FAIL bp_tail got v=%b src=%0d exp v=1 src=1", pred_valid, pred_src);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (pred_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_drain got v=%b exp v=0", pred_valid);
        end
        step();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_enable_mask();
        logic [3:0] er;
        logic [1:0] es;
        cfg_enable = 4'b1010;
        req_valid  = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            er = gnt_retry(((k % 2) == 0) ? 3 : 1);
            n_vec++;
            if (req_retry !== er) begin
                n_err++; $display("FAIL mask_retry k=%0d got=%b exp=%b", k, req_retry, er);
            end
            if (k >= 1) begin
                es = ((k % 2) == 1) ? 2'd3 : 2'd1;
                n_vec++;
                if (pred_valid !== 1'b1 || pred_src !== es || pred_data !== dat[es]) begin
                    n_err++;
                    $display("FAIL mask_out k=%0d got v=%b src=%0d exp v=1 src=%0d",
                             k, pred_valid, pred_src, es);
                end
            end
            step();
        end
        cfg_enable = 4'b0000;
        @(negedge clk);
        n_vec++;
        if (req_retry !== 4'b1111 || pred_valid !== 1'b1 || pred_src !== 2'd1) begin
            n_err++;
            $display("FAIL mask_off got retry=%b v=%b src=%0d exp retry=1111 v=1 src=1",
                     req_retry, pred_valid, pred_src);
        end
        step();
        req_valid  = '0;
        cfg_enable = '1;
        repeat (2) step();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_async_reset();
        logic [3:0] er [4];
        er = '{4'b1110, 4'b1111, 4'b1111, 4'b1101};
        pred_retry  = 1'b1;
        cfg_min_gap = 4'd2;
        req_valid   = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if (req_retry !== er[k]) begin
                n_err++; $display("FAIL ar_fill k=%0d got=%b exp=%b", k, req_retry, er[k]);
            end
            step();
        end
        n_vec++;
        if (pred_valid !== 1'b1 || pred_src !== 2'd0) begin
            n_err++; $display("FAIL ar_pre got v=%b src=%0d exp v=1 src=0", pred_valid, pred_src);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (pred_valid !== 1'b0 || pred_src !== 2'd0 || pred_data !== 64'd0 ||
            req_retry !== 4'b1111) begin
            n_err++;
            $display("FAIL ar_async got v=%b src=%0d data=%h retry=%b exp v=0 src=0 data=0 retry=1111",
                     pred_valid, pred_src, pred_data, req_retry);
        end
        pred_retry = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_retry !== 4'b1110) begin
            n_err++; $display("FAIL ar_first got=%b exp=1110", req_retry);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_src !== 2'd0 || pred_data !== dat[0] ||
            req_retry !== 4'b1111) begin
            n_err++;
            $display("FAIL ar_after got v=%b src=%0d retry=%b exp v=1 src=0 retry=1111",
                     pred_valid, pred_src, req_retry);
        end
        step();
        req_valid   = '0;
        cfg_min_gap = '0;
        repeat (4) step();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        logic [DATA_W-1:0] q_data [$];
        logic [1:0]        q_src  [$];
        logic [31:0]       seq    [NREQ];
        int                wait_cnt [NREQ];
        logic [3:0]        acc;
        logic [3:0]        bad;
        acc = '0;
        for (int i = 0; i < NREQ; i++) begin
            seq[i]      = '0;
            wait_cnt[i] = 0;
        end
        cfg_enable = '1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    if (acc[i]) seq[i] = seq[i] + 32'd1;
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                end
                req_data[i*DATA_W +: DATA_W] = {8'(i), 24'h5A5A5A, seq[i]};
            end
            if ($urandom_range(0, 15) == 0) cfg_enable = 4'($urandom);
            pred_retry = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            // Delivery check runs before this cycle's acceptances are queued:
            // an entry accepted now cannot legally leave in the same cycle.
            if (pred_valid && !pred_retry) begin
                n_vec++;
                if (q_data.size() == 0) begin
                    n_err++; $display("FAIL rnd_spurious cyc=%0d got src=%0d data=%h exp nothing",
                                      cyc, pred_src, pred_data);
                end else begin
                    if (pred_data !== q_data[0] || pred_src !== q_src[0]) begin
                        n_err++;
                        $display("FAIL rnd_order cyc=%0d got src=%0d data=%h exp src=%0d data=%h",
                                 cyc, pred_src, pred_data, q_src[0], q_data[0]);
                    end
                    void'(q_data.pop_front());
                    void'(q_src.pop_front());
                end
            end
            acc = req_valid & ~req_retry;
            bad = ~req_retry & ~(req_valid & cfg_enable);
            n_vec++;
            if ($countones(~req_retry) > 1 || bad != 4'b0000) begin
                n_err++; $display("FAIL rnd_retry cyc=%0d got=%b valid=%b en=%b exp one-hot on candidate",
                                  cyc, req_retry, req_valid, cfg_enable);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    q_data.push_back(req_data[i*DATA_W +: DATA_W]);
                    q_src.push_back(2'(i));
                    wait_cnt[i] = 0;
                end else if (req_valid[i] && cfg_enable[i]) begin
                    if (acc != 4'b0000) begin
                        wait_cnt[i]++;
                        n_vec++;
                        if (wait_cnt[i] > NREQ - 1) begin
                            n_err++; $display("FAIL rnd_fair cyc=%0d src=%0d got waits=%0d exp<=%0d",
                                              cyc, i, wait_cnt[i], NREQ - 1);
                        end
                    end
                end else begin
                    wait_cnt[i] = 0;
                end
            end
            step();
        end
        req_valid  = '0;
        pred_retry = 1'b0;
        for (int d = 0; d < 10; d++) begin
            @(negedge clk);
            if (pred_valid) begin
                n_vec++;
                if (q_data.size() == 0) begin
                    n_err++; $display("FAIL rnd_drain_extra got src=%0d exp nothing", pred_src);
                end else begin
                    if (pred_data !== q_data[0] || pred_src !== q_src[0]) begin
                        n_err++;
                        $display("FAIL rnd_drain got src=%0d data=%h exp src=%0d data=%h",
                                 pred_src, pred_data, q_src[0], q_data[0]);
                    end
                    void'(q_data.pop_front());
                    void'(q_src.pop_front());
                end
            end
            step();
        end
        n_vec++;
        if (q_data.size() != 0 || pred_valid !== 1'b0) begin
            n_err++; $display("FAIL rnd_loss got left=%0d v=%b exp left=0 v=0", q_data.size(), pred_valid);
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        reset       = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        cfg_enable  = '1;
        cfg_min_gap = '0;
        pred_retry  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            dat[i] = 64'hA5C3_0000_0000_0000 ^ (64'(i + 1) << (i * 12));
        end
        test_reset();
        test_round_robin();
        test_min_gap();
        test_backpressure();
        test_enable_mask();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pfm_pred_arb.md
Name: pfm_pred_arb

Overview:
- Schedules prefetch predictions from NREQ independent prediction engines (stride table, stream detector, L2-miss monitor, ...) onto the single prefetch-monitor-to-core prediction channel.
- Round-robin arbitration with a per-source enable mask and a programmable minimum issue gap.
- A 2-entry output buffer fully decouples the downstream retry from the upstream retries.
- Sits inside the prefetch monitor, between the prediction engines and the core-facing prediction flop.

Parameters:
- NREQ, 4, number of prediction sources (2..8).
- DATA_W, 64, width of one prediction payload.
- GAP_W, 4, width of the minimum-issue-gap configuration field.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_data  in  NREQ*DATA_W  flattened payloads; source i occupies bits [i*DATA_W +: DATA_W].
- req_valid  in  NREQ  per-source valid.
- req_retry  out  NREQ  per-source retry; 1 = not accepted this cycle.
- cfg_enable  in  NREQ  per-source enable mask.
- cfg_min_gap  in  GAP_W  idle cycles forced between consecutive grants.
- pred_data  out  DATA_W  payload at buffer head.
- pred_src  out  clog2(NREQ)  source index of the head entry.
- pred_valid  out  1  buffer non-empty.
- pred_retry  in  1  downstream retry.

Behaviour:
Handshake:
- A transfer on any channel occurs in a cycle where valid=1 and retry=0.
- A sender keeps valid and data stable while retry=1.

Reset (reset=0, asynchronous):
- pred_valid=0, pred_data=0, pred_src=0.
- Buffer count=0, rr_ptr=0, gap_cnt=0.
- Buffered entries are discarded. Assertion mid-operation drops them; no partial transfer.
- req_retry is combinational and equals all-ones while reset=0.

Grant eligibility (all use registered state, so there is no combinational path from pred_retry to req_retry):
- Arbitration occurs when count<2 and gap_cnt==0.
- Candidates are sources with req_valid[i]&cfg_enable[i].
- The winner is the first candidate scanning from rr_ptr upward, with modulo-NREQ wrap.

Per-cycle effect of a grant g:
- req_retry[g]=0; all other req_retry bits are 1.
- Push {g, req_data[g]} into the tail.
- rr_ptr <= (g+1) mod NREQ.
- gap_cnt <= cfg_min_gap.

Non-grant cycles:
- All req_retry bits are 1.
- rr_ptr is unchanged.
- gap_cnt decrements if non-zero and saturates at 0.

Disabled sources:
- A disabled source always sees retry=1.
- Mask changes take effect in the same cycle.

Output buffer:
- 2-entry FIFO.
- pred_valid = (count!=0); pred_data and pred_src come from the head.
- Pop when pred_valid & ~pred_retry.
- Push and pop in the same cycle are legal. Count is unchanged and ordering is preserved.
- With count==2 there is no push, even if a pop happens that cycle.

Latency and throughput:
- A granted request appears on pred_valid the next cycle.
- With cfg_min_gap=0, sustained throughput is 1/cycle.
- With gap G, at most one grant per G+1 cycles.

Fairness:
- With all sources continuously valid and enabled, grants rotate 0,1,...,NREQ-1,0.
- No source waits more than NREQ-1 grants.

Invariants:
- Count never exceeds 2.
- No payload is duplicated or lost except by reset.
- At most one req_retry bit is 0 per cycle.

Test Plan:
- Reset, then all 4 sources valid, enabled, gap=0, pred_retry=0 -> pred_src sequence 0,1,2,3,0,1 on consecutive cycles starting 1 cycle after the first grant; data matches each source.
- cfg_min_gap=3, source 2 only, continuously valid -> grants on cycles t, t+4, t+8; req_retry[2]=1 in between.
- pred_retry held 1 with sources 0 and 1 valid -> exactly 2 entries accepted (src0, src1), then all req_retry=1. Release retry -> src0 out, then src1, then the next grant resumes with src0 (rr_ptr=2 wraps).
- cfg_enable=4'b1010 with all valid -> only sources 1 and 3 alternate; req_retry[0] and req_retry[2] stay 1.
- Asynchronous reset pulse while count=2 and gap_cnt=2 -> pred_valid falls immediately. After release, first grant goes to source 0 on the first cycle with no gap wait.
- Random valid/retry/enable over 10k cycles against a scoreboard -> in-order delivery per source, no loss or duplication, fairness bound NREQ-1 holds.
